// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the shared-unit arbiter.
// Round-robin selection is enabled by defining ARB_RR_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_CNT_W   = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin from ptr with ARB_RR_EN,
// otherwise a plain lowest-index priority encoder.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);

  logic [IW-1:0] j;
  logic          found;

`ifndef ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
`ifdef ARB_RR_EN
      j = IW'((i + int'(ptr)) % N);
`else
      j = IW'(i);
`endif
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end

endmodule

// File: rtl/shared_unit_arbiter.sv
// N-way arbiter in front of one fixed-latency shared unit.
// Define ARB_RR_EN for round-robin; default build is fixed priority.
module shared_unit_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] op_a,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    unit_start,
  output logic [DATA_W-1:0]       unit_a,
  input  logic [DATA_W-1:0]       unit_y,
  output logic                    busy
);

  localparam int IW = idx_w(N_REQ);

  arb_state_t           state, state_nx;
  logic [ARB_CNT_W-1:0] cnt, cnt_nx;
  logic [IW-1:0]        win_idx, pick_idx, ptr;
  logic [N_REQ-1:0]     pick_oh;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (pick_oh),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (|req) state_nx = ISSUE;
      end
      ISSUE: begin
        cnt_nx   = ARB_CNT_W'(LAT - 1);
        state_nx = (LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt_nx == '0) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      win_idx    <= '0;
      gnt        <= '0;
      done       <= '0;
      rsp_data   <= '0;
      unit_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      unit_start <= (state_nx == ISSUE);
      busy       <= (state_nx != IDLE);
      done       <= '0;
      if (state == IDLE && |req) begin
        win_idx <= pick_idx;
        gnt     <= pick_oh;
      end
      if (state == DONE) begin
        gnt      <= '0;
        done     <= gnt;
        rsp_data <= unit_y;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (state == DONE) begin
      ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Operand mux follows the registered winner, not the live request.
  assign unit_a = (state == IDLE) ? '0
                : op_a[int'(win_idx)*DATA_W +: DATA_W];

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Scoreboard bench: LAT=1 and LAT=4 arbiters, each with an inverter unit.
// Expected order follows ARB_RR_EN the same way the design does.
module tb_shared_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0] oh;
    logic [W-1:0] rsp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [N-1:0]   req  [2];
  logic [N*W-1:0] op   [2];
  logic [N-1:0]   gnt  [2];
  logic [N-1:0]   done [2];
  logic [W-1:0]   rsp  [2];
  logic [W-1:0]   ua   [2];
  logic [W-1:0]   uy   [2];
  logic           st   [2];
  logic           busy [2];

  exp_t lg0[$];

  function automatic int pick(input logic [N-1:0] r, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 4;

    logic         vv [L];
    logic [W-1:0] dd [L];
    exp_t         q[$];
    exp_t         e;
    int           m_cnt, m_ptr, m_w, p;
    logic [N-1:0] m_gnt, m_done;
    logic         m_start;

    shared_unit_arbiter #(
      .N_REQ  (N),
      .DATA_W (W),
      .LAT    (L)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req[g]),
      .op_a       (op[g]),
      .gnt        (gnt[g]),
      .done       (done[g]),
      .rsp_data   (rsp[g]),
      .unit_start (st[g]),
      .unit_a     (ua[g]),
      .unit_y     (uy[g]),
      .busy       (busy[g])
    );

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < L; i++) begin
          vv[i] <= 1'b0;
          dd[i] <= '0;
        end
      end else begin
        vv[0] <= st[g];
        dd[0] <= ~ua[g];
        for (int i = 1; i < L; i++) begin
          vv[i] <= vv[i-1];
          dd[i] <= dd[i-1];
        end
      end
    end
    assign uy[g] = vv[L-1] ? dd[L-1] : '0;

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        m_cnt   <= 0;
        m_ptr   <= 0;
        m_w     <= 0;
        m_gnt   <= '0;
        m_done  <= '0;
        m_start <= 1'b0;
        q.delete();
      end else begin
        m_start <= 1'b0;
        m_done  <= '0;
        if (m_cnt != 0) begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_gnt  <= '0;
            m_done <= m_gnt;
          end
        end else if (req[g] != '0) begin
          p = pick(req[g], m_ptr);
          m_w     <= p;
          m_gnt   <= N'(1) << p;
          m_cnt   <= L + 1;
          m_start <= 1'b1;
          q.push_back({N'(1) << p, ~op[g][p*W +: W]});
`ifdef ARB_RR_EN
          m_ptr <= (p + 1) % N;
`endif
        end
      end
    end

    always @(negedge clk) begin
      if (reset) begin
        check(g ? "gnt4" : "gnt1", gnt[g], m_gnt);
        check(g ? "busy4" : "busy1", busy[g], m_gnt != '0);
        check(g ? "start4" : "start1", st[g], m_start);
        check(g ? "ua4" : "ua1", ua[g],
              (m_gnt != '0) ? op[g][m_w*W +: W] : '0);
        check(g ? "done4" : "done1", done[g], m_done);
        if (m_done != '0) begin
          if (q.size() == 0) begin
            check(g ? "sb4" : "sb1", 1, 0);
          end else begin
            e = q.pop_front();
            check(g ? "rsp4" : "rsp1", rsp[g], e.rsp);
          end
        end
        if (g == 0 && done[g] != '0) lg0.push_back({done[g], rsp[g]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2;
    reset  = 1'b0;
    req[0] = '0;
    req[1] = '0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  logic [N-1:0] oh_t[5];
  logic [W-1:0] rs_t[5];
  int b, nst, dcyc;

  initial begin
    req[0] = '0;
    req[1] = '0;
    op[0]  = '0;
    op[1]  = '0;
    tick(2);
    check("rst_gnt", gnt[0], 0);
    check("rst_busy", busy[1], 0);
    check("rst_ua", ua[0], 0);
    reset = 1'b1;
    tick(2);

    // single request, LAT=1
    rst_pulse();
    op[0]  = {8'h00, 8'h00, 8'h00, 8'h3C};
    req[0] = 4'b0001;
    @(posedge clk); #1;
    check("s1_gnt", gnt[0], 4'b0001);
    check("s1_ua", ua[0], 8'h3C);
    @(posedge clk); #1;
    req[0] = '0;
    @(posedge clk); #1;
    check("s1_done", done[0], 4'b0001);
    check("s1_rsp", rsp[0], 8'hC3);
    tick(2);

    // four continuous requesters
    rst_pulse();
    b      = lg0.size();
    op[0]  = {8'hFF, 8'hF0, 8'h0F, 8'h00};
    req[0] = 4'b1111;
`ifdef ARB_RR_EN
    oh_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rs_t = '{8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFF};
`else
    oh_t = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rs_t = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    repeat (13) @(posedge clk);
    #2;
    req[0] = '0;
    tick(5);
    check("s2_cnt", lg0.size(), b + 5);
    for (int i = 0; i < 5; i++) begin
      if (lg0.size() > b + i) begin
        check("s2_oh", lg0[b+i].oh, oh_t[i]);
        check("s2_rsp", lg0[b+i].rsp, rs_t[i]);
      end
    end

    // LAT=4 single transaction
    rst_pulse();
    op[1]  = {8'h00, 8'hA5, 8'h00, 8'h00};
    req[1] = 4'b0100;
    nst    = 0;
    dcyc   = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) req[1] = '0;
      if (st[1]) nst++;
      if (done[1] == 4'b0100) dcyc = i;
    end
    check("s3_starts", nst, 1);
    check("s3_done_cyc", dcyc, 5);
    check("s3_rsp", rsp[1], 8'h5A);
    tick(1);

    // reset during WAIT, then pointer back at 0
    req[1] = 4'b0100;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("s4_gnt", gnt[1], 0);
    check("s4_done", done[1], 0);
    check("s4_rsp", rsp[1], 0);
    check("s4_start", st[1], 0);
    check("s4_ua", ua[1], 0);
    check("s4_busy", busy[1], 0);
    req[1] = 4'b1010;
    op[1]  = {8'h77, 8'h00, 8'h66, 8'h00};
    tick(2);
    check("s4_done_rst", done[1], 0);
    reset = 1'b1;
    @(posedge clk); #1;
    req[1] = '0;
    check("s4_gnt_post", gnt[1], 4'b0010);
    repeat (5) @(posedge clk);
    #1;
    check("s4_done_post", done[1], 4'b0010);
    check("s4_rsp_post", rsp[1], 8'h99);
    tick(2);

    // request dropped right after grant
    rst_pulse();
    op[0]  = {8'h00, 8'h00, 8'h5E, 8'h00};
    req[0] = 4'b0010;
    @(posedge clk); #1;
    req[0] = '0;
    check("s5_gnt", gnt[0], 4'b0010);
    repeat (2) @(posedge clk);
    #1;
    check("s5_done", done[0], 4'b0010);
    check("s5_rsp", rsp[0], 8'hA1);
    @(posedge clk); #1;
    check("s5_busy", busy[0], 0);
    check("s5_gnt_clr", gnt[0], 0);
    tick(2);

    // all four held for three transactions
    rst_pulse();
    b      = lg0.size();
    op[0]  = {8'h44, 8'h33, 8'h22, 8'h11};
    req[0] = 4'b1111;
`ifdef ARB_RR_EN
    oh_t = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    rs_t = '{8'hEE, 8'hDD, 8'hCC, 8'h00, 8'h00};
`else
    oh_t = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    rs_t = '{8'hEE, 8'hEE, 8'hEE, 8'h00, 8'h00};
`endif
    repeat (7) @(posedge clk);
    #2;
    req[0] = '0;
    tick(5);
    check("s6_cnt", lg0.size(), b + 3);
    for (int i = 0; i < 3; i++) begin
      if (lg0.size() > b + i) begin
        check("s6_oh", lg0[b+i].oh, oh_t[i]);
        check("s6_rsp", lg0[b+i].rsp, rs_t[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/shared_unit_arbiter.md
# shared_unit_arbiter

Arbitrates N requesters for one shared, fixed-latency functional unit (the inverter/ALU slice of the ADDAC datapath). It selects one request, forwards that requester's operand to the unit, waits the unit's pipeline latency, then captures the result and returns it with a one-cycle done pulse. It sits between the issuing control logic and the shared unit, and is the only block allowed to drive the unit's inputs.

## Interface
- N_REQ, 4: number of requesters (2..8).
- DATA_W, 32: operand/result width.
- LAT, 1: unit latency in cycles from `unit_start` to a valid `unit_y` (1..15).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- req  in  N_REQ  per-requester request level.
- op_a  in  N_REQ*DATA_W  operands; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot grant; held for the whole transaction.
- done  out  N_REQ  one-hot, one-cycle completion pulse.
- rsp_data  out  DATA_W  captured unit result.
- unit_start  out  1  one-cycle launch strobe to the shared unit.
- unit_a  out  DATA_W  operand to the unit.
- unit_y  in  DATA_W  unit result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `req` bit is high at a rising edge, latch the winner index, go to ISSUE, and set `gnt[winner]`. If `req` is all zeros, stay in IDLE.
- ISSUE (1 cycle): `unit_start`=1. Load the wait counter with LAT-1. If LAT=1, go straight to DONE; otherwise go to WAIT.
- WAIT: decrement the counter. Go to DONE when the counter reaches 0.
- DONE (1 cycle): `rsp_data` ← `unit_y`; `done[winner]`=1; `gnt` clears at the next edge. Update the priority pointer. Return to IDLE.
- `unit_a` = `op_a[winner]` from ISSUE through DONE. It is 0 in IDLE.
- Requesters must hold `op_a` stable while `req` is high. Dropping `req` mid-transaction does not abort: the transaction completes and `done` still pulses.
- A `req` still high in the IDLE cycle after DONE is treated as a new request.
- Winner selection: see Configuration. The pointer resets to 0.
- `rsp_data` holds its value until the next DONE.

## Timing
- Reset values: `gnt`=0, `done`=0, `rsp_data`=0, `unit_start`=0, `unit_a`=0, `busy`=0, state=IDLE, pointer=0, counter=0.
- `req` is sampled at edge E0. `gnt`/`unit_start`/`busy` are high after E0. `unit_y` is captured at edge E0+LAT+1. `done` is high from E0+LAT+1 to E0+LAT+2.
- Minimum spacing between consecutive grants: LAT+2 edges (the DONE cycle is followed by at least one IDLE cycle).
- Simultaneous requests: exactly one grant; losers wait without any indication.
- Reset asserted mid-transaction: immediate return to reset values. No `done` is issued for the aborted transaction.
- All outputs are registered except `unit_a`, which is a mux driven from the registered winner index.

## Configuration
- `ARB_RR_EN` defined: round-robin. The search starts at the pointer; after each DONE, pointer = (winner+1) mod N_REQ.
- `ARB_RR_EN` not defined: fixed priority. The lowest requesting index always wins and the pointer logic is absent.
- The port list is identical in both builds.

## Structure
- Shared package `arb_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, WAIT, DONE);
  - `ARB_MAX_REQ`=8;
  - `ARB_CNT_W`=4;
  - function `idx_w(n)`.
- One sub-module: `rr_pick`. It is combinational: inputs `req` and pointer, output one-hot winner plus its index. With the macro absent it degenerates to a priority encoder.
- The FSM, counter, capture register and operand mux live in the top module.

## Test plan
Configuration for all scenarios: N_REQ=4, DATA_W=8, LAT=1, `ARB_RR_EN` defined. The bench models the unit as a registered inverter (`unit_y` = ~`unit_a`, one cycle after `unit_start`).

- Single request: `req`=0001, op_a[0]=8'h3C → `gnt`=0001 after E0, `unit_a`=8'h3C, `done`=0001 at E0+2, `rsp_data`=8'hC3.
- All four requesting continuously, operands 8'h00/8'h0F/8'hF0/8'hFF → grants in order 0,1,2,3,0; `rsp_data` sequence FF,F0,0F,00; grant edges 3 cycles apart.
- LAT=4, `req`=0100, op_a[2]=8'hA5 → `unit_start` high for exactly one cycle; `done`=0100 at E0+5; `rsp_data`=8'h5A.
- `reset` driven to 0 during WAIT (LAT=4) → all outputs 0 in the same cycle, no `done`. After release, `req`=0010 wins first because the pointer was reset.
- `req[1]` dropped one cycle after grant → `done`=0010 still pulses and `rsp_data` is updated. With no other requests, the next cycle is IDLE with `busy`=0.
- Build without `ARB_RR_EN`, `req`=1111 held for 3 transactions → all three grants go to requester 0.
